// File: rtl/lsu_pkg.sv
// Shared types for the LSU sequencer: FSM states, access sizes, and the load/store opcode encodings.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   localparam logic [2:0] ST_SB  = 3'b000;
   localparam logic [2:0] ST_SH  = 3'b001;
   localparam logic [2:0] ST_SW  = 3'b010;

   // Undefined codes fall back to a full word access.
   function automatic size_t access_size(input logic       wren,
                                         input logic [2:0] ld_type,
                                         input logic [2:0] st_size);
      size_t sz;
      sz = SZ_W;
      if (wren) begin
         case (st_size)
            ST_SB:   sz = SZ_B;
            ST_SH:   sz = SZ_H;
            ST_SW:   sz = SZ_W;
            default: sz = SZ_W;
         endcase
      end else begin
         case (ld_type)
            LD_LB, LD_LBU: sz = SZ_B;
            LD_LH, LD_LHU: sz = SZ_H;
            LD_LW:         sz = SZ_W;
            default:       sz = SZ_W;
         endcase
      end
      return sz;
   endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load formatter: moves the addressed byte/halfword of a bus word to bit 0, then sign- or zero-extends it.
module lsu_ld_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_load_type,
   input  logic [1:0]  i_byte_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [31:0] w_byte_sh;
   logic [31:0] w_half_sh;

   assign w_byte_sh = i_rdata >> {i_byte_off, 3'b000};
   assign w_half_sh = i_rdata >> {i_byte_off[1], 4'b0000};

   // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
   always_comb begin
      o_data = i_rdata;
      case (i_load_type)
         LD_LB:   o_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
         LD_LBU:  o_data = {24'd0, w_byte_sh[7:0]};
         LD_LH:   o_data = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
         LD_LHU:  o_data = {16'd0, w_half_sh[15:0]};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer between the core and a req/ack data bus.
// Optional LSU_MISALIGN_CHK_EN: misaligned accesses abort to ERR without touching the bus.
module lsu_sequencer
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int ADDR_W      = 32
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_mem_req,
   input  logic              i_wren,
   input  logic [2:0]        i_load_type,
   input  logic [2:0]        i_slt_sl,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_stall,
   output logic              o_done,
   output logic              o_err,
   output logic [31:0]       o_ld_data,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [31:0]       o_bus_wdata,
   output logic [3:0]        o_bus_bmask,
   input  logic              i_bus_ack,
   input  logic [31:0]       i_bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   state_t            r_state, w_next;
   logic              r_wren;
   logic [2:0]        r_ld_type;
   size_t             r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_ld_data;
   logic [31:0]       w_ld_fmt;
   size_t             w_in_size;
   logic              w_misalign;

   assign w_in_size = access_size(i_wren, i_load_type, i_slt_sl);

`ifdef LSU_MISALIGN_CHK_EN
   assign w_misalign = ((w_in_size == SZ_H) && i_addr[0]) ||
                       ((w_in_size == SZ_W) && (i_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   lsu_ld_align u_ld_align (
      .i_load_type (r_ld_type),
      .i_byte_off  (r_addr[1:0]),
      .i_rdata     (i_bus_rdata),
      .o_data      (w_ld_fmt)
   );

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= IDLE;
         r_wren    <= 1'b0;
         r_ld_type <= LD_LW;
         r_size    <= SZ_W;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_ld_data <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: if (i_mem_req) begin
               r_wren    <= i_wren;
               r_ld_type <= i_load_type;
               r_size    <= w_in_size;
               r_addr    <= i_addr;
               r_wdata   <= i_wdata;
               r_cnt     <= '0;
               r_ld_data <= '0;
            end
            REQ: begin
               r_cnt <= r_cnt + 1'b1;
               if (i_bus_ack) r_ld_data <= r_wren ? 32'd0 : w_ld_fmt;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      o_stall   = 1'b0;
      o_done    = 1'b0;
      o_err     = 1'b0;
      o_bus_req = 1'b0;
      case (r_state)
         IDLE: if (i_mem_req) begin
            o_stall = 1'b1;
            w_next  = w_misalign ? ERR : REQ;
         end
         REQ: begin
            o_stall   = 1'b1;
            o_bus_req = 1'b1;
            // An ack on the last allowed cycle still completes the access.
            if (i_bus_ack)                                 w_next = RESP;
            else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1))     w_next = ERR;
         end
         RESP: begin
            o_done = 1'b1;
            w_next = IDLE;
         end
         ERR: begin
            o_done = 1'b1;
            o_err  = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_bus_bmask = 4'b0000;
      o_bus_wdata = 32'd0;
      if (r_state == REQ) begin
         o_bus_bmask = 4'b1111;
         if (r_wren) begin
            case (r_size)
               SZ_B: begin
                  o_bus_bmask = 4'b0001 << r_addr[1:0];
                  o_bus_wdata = {4{r_wdata[7:0]}};
               end
               SZ_H: begin
                  o_bus_bmask = 4'b0011 << {r_addr[1], 1'b0};
                  o_bus_wdata = {2{r_wdata[15:0]}};
               end
               default: o_bus_wdata = r_wdata;
            endcase
         end
      end
   end

   assign o_bus_we   = o_bus_req & r_wren;
   assign o_bus_addr = o_bus_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign o_ld_data  = (r_state == RESP) ? r_ld_data : 32'd0;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: directed corner cases plus randomized accesses against a byte-level model.
module tb_lsu_sequencer;

   localparam int TO = 16;
   localparam int AW = 32;

   logic          i_clk, i_reset, i_mem_req, i_wren;
   logic [2:0]    i_load_type, i_slt_sl;
   logic [AW-1:0] i_addr;
   logic [31:0]   i_wdata;
   logic          o_stall, o_done, o_err;
   logic [31:0]   o_ld_data;
   logic          o_bus_req, o_bus_we;
   logic [AW-1:0] o_bus_addr;
   logic [31:0]   o_bus_wdata;
   logic [3:0]    o_bus_bmask;
   logic          i_bus_ack;
   logic [31:0]   i_bus_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   lsu_sequencer #(.TIMEOUT_CYC(TO), .ADDR_W(AW)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_mem_req   (i_mem_req),
      .i_wren      (i_wren),
      .i_load_type (i_load_type),
      .i_slt_sl    (i_slt_sl),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .o_stall     (o_stall),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_ld_data   (o_ld_data),
      .o_bus_req   (o_bus_req),
      .o_bus_we    (o_bus_we),
      .o_bus_addr  (o_bus_addr),
      .o_bus_wdata (o_bus_wdata),
      .o_bus_bmask (o_bus_bmask),
      .i_bus_ack   (i_bus_ack),
      .i_bus_rdata (i_bus_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- reference model ----------------
   function automatic int model_bytes(input logic wr, input logic [2:0] lt, input logic [2:0] ss);
      if (wr) return (ss == 3'd0) ? 1 : (ss == 3'd1) ? 2 : 4;
      if (lt == 3'd0 || lt == 3'd4) return 1;
      if (lt == 3'd1 || lt == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic model_misaligned(input int n, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHK_EN
      return (a % n) != 0;
`else
      return (n < 0) && (a == 0);
`endif
   endfunction

   // {we, word address, byte mask, write data}
   function automatic logic [68:0] model_bus(input logic wr, input logic [2:0] lt, input logic [2:0] ss,
                                             input logic [31:0] a, input logic [31:0] wd);
      int          n;
      logic [3:0]  m;
      logic [31:0] w;
      n = model_bytes(wr, lt, ss);
      m = 4'hF;
      w = 32'd0;
      if (wr) begin
         case (n)
            1: begin
               m = 4'(1 << (a % 4));
               w = (wd & 32'hFF) * 32'h0101_0101;
            end
            2: begin
               m = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
               w = (wd & 32'hFFFF) * 32'h0001_0001;
            end
            default: w = wd;
         endcase
      end
      return {wr, a - (a % 4), m, w};
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      case (model_bytes(1'b0, lt, 3'd0))
         1: begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (lt == 3'd0 && v >= 32'd128) v = v - 32'd256;
         end
         2: begin
            v = (rd >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
            if (lt == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
         end
         default: v = rd;
      endcase
      return v;
   endfunction

   // ---------------- access driver ----------------
   // ack_at: REQ cycle index on which ack is given (-1 = never). hold keeps i_mem_req high after o_done.
   task automatic do_access(input string tag, input logic wr, input logic [2:0] lt, input logic [2:0] ss,
                            input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                            input logic [31:0] rd, input logic hold);
      logic [68:0] exp_bus;
      logic [31:0] exp_ld;
      logic        mis, exp_err, acked;
      mis     = model_misaligned(model_bytes(wr, lt, ss), a);
      exp_bus = model_bus(wr, lt, ss, a, wd);
      exp_ld  = wr ? 32'd0 : model_load(lt, a, rd);
      acked   = 1'b0;

      @(negedge i_clk);
      i_mem_req = 1'b1; i_wren = wr; i_load_type = lt; i_slt_sl = ss; i_addr = a; i_wdata = wd;
      #1;
      n_cmp++;
      if ({o_stall, o_done, o_err, o_bus_req} !== 4'b1000) begin
         n_bad++;
         $display("FAIL %s accept: {stall,done,err,req}=%b want 1000", tag, {o_stall, o_done, o_err, o_bus_req});
      end

      if (!mis) begin
         for (int k = 0; k < TO; k++) begin
            @(negedge i_clk);
            i_mem_req   = hold;
            i_bus_ack   = (k == ack_at);
            i_bus_rdata = (k == ack_at) ? rd : $urandom;
            #1;
            n_cmp++;
            if ({o_stall, o_done, o_err, o_bus_req, o_bus_we, o_bus_addr, o_bus_bmask} !==
                {4'b1001, exp_bus[68:32]}) begin
               n_bad++;
               $display("FAIL %s req[%0d]: st/dn/er/rq=%b we=%b addr=%h mask=%b want we=%b addr=%h mask=%b",
                        tag, k, {o_stall, o_done, o_err, o_bus_req}, o_bus_we, o_bus_addr, o_bus_bmask,
                        exp_bus[68], exp_bus[67:36], exp_bus[35:32]);
            end
            if (wr) begin
               n_cmp++;
               if (o_bus_wdata !== exp_bus[31:0]) begin
                  n_bad++;
                  $display("FAIL %s wdata[%0d]: got %h want %h", tag, k, o_bus_wdata, exp_bus[31:0]);
               end
            end
            if (k == ack_at) begin
               acked = 1'b1;
               break;
            end
         end
      end
      exp_err = !acked;

      @(negedge i_clk);
      i_bus_ack = 1'b0;
      i_mem_req = hold;
      #1;
      n_cmp++;
      if ({o_stall, o_done, o_err, o_bus_req, o_ld_data} !== {2'b01, exp_err, 1'b0, exp_err ? 32'd0 : exp_ld}) begin
         n_bad++;
         $display("FAIL %s done: st/dn/er/rq=%b ld=%h want dn=1 er=%b ld=%h", tag,
                  {o_stall, o_done, o_err, o_bus_req}, o_ld_data, exp_err, exp_err ? 32'd0 : exp_ld);
      end

      @(negedge i_clk);
      #1;
      n_cmp++;
      if ({o_stall, o_done, o_err, o_bus_req} !== {hold, 3'b000}) begin
         n_bad++;
         $display("FAIL %s after: {stall,done,err,req}=%b want %b000", tag,
                  {o_stall, o_done, o_err, o_bus_req}, hold);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_reset = 1'b0; i_mem_req = 1'b0; i_wren = 1'b0; i_load_type = 3'd0; i_slt_sl = 3'd0;
      i_addr = '0; i_wdata = '0; i_bus_ack = 1'b0; i_bus_rdata = '0;
      repeat (3) @(negedge i_clk);
      n_cmp++;
      if ({o_stall, o_done, o_err, o_ld_data, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_bmask} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: req=%b stall=%b done=%b addr=%h mask=%b want all 0",
                  o_bus_req, o_stall, o_done, o_bus_addr, o_bus_bmask);
      end
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      #1;
      n_cmp++;
      if ({o_stall, o_done, o_err, o_bus_req} !== 4'b0000) begin
         n_bad++;
         $display("FAIL idle_no_req: {stall,done,err,req}=%b want 0000", {o_stall, o_done, o_err, o_bus_req});
      end
   endtask

   task automatic test_directed();
      do_access("lw_100",  1'b0, 3'b010, 3'd0, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
      do_access("lb_103",  1'b0, 3'b000, 3'd0, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0);
      do_access("lbu_103", 1'b0, 3'b100, 3'd0, 32'h103, 32'h0, 1, 32'h80FF_0000, 1'b0);
      do_access("sh_202",  1'b1, 3'd0, 3'b001, 32'h202, 32'h1234_ABCD, 0, 32'h0, 1'b0);
      do_access("lh_102",  1'b0, 3'b001, 3'd0, 32'h102, 32'h0, 3, 32'h8001_7FFF, 1'b0);
      do_access("sb_001",  1'b1, 3'd0, 3'b000, 32'h001, 32'h0000_005A, 1, 32'h0, 1'b0);
   endtask

   task automatic test_timeout();
      do_access("timeout",     1'b0, 3'b010, 3'd0, 32'h40, 32'h0, -1, 32'h1111_2222, 1'b0);
      do_access("ack_last",    1'b0, 3'b010, 3'd0, 32'h44, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0);
      do_access("store_to",    1'b1, 3'd0, 3'b010, 32'h48, 32'h5555_AAAA, -1, 32'h0, 1'b0);
   endtask

   task automatic test_misalign();
      do_access("lw_101", 1'b0, 3'b010, 3'd0, 32'h101, 32'h0, 1, 32'h0102_0304, 1'b0);
      do_access("sh_203", 1'b1, 3'd0, 3'b001, 32'h203, 32'h0000_BEEF, 0, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      rd = $urandom;
      // First access leaves i_mem_req high, which re-arms the sequencer for a second access.
      do_access("b2b_first", 1'b0, 3'b010, 3'd0, 32'h300, 32'h0, 0, 32'h7777_8888, 1'b1);
      @(negedge i_clk);
      i_mem_req = 1'b0; i_bus_ack = 1'b1; i_bus_rdata = rd;
      #1;
      n_cmp++;
      if ({o_stall, o_bus_req, o_bus_addr} !== {2'b11, 32'h300}) begin
         n_bad++;
         $display("FAIL b2b_req: stall=%b req=%b addr=%h want 1 1 00000300", o_stall, o_bus_req, o_bus_addr);
      end
      @(negedge i_clk);
      i_bus_ack = 1'b0;
      #1;
      n_cmp++;
      if ({o_done, o_err, o_ld_data} !== {2'b10, rd}) begin
         n_bad++;
         $display("FAIL b2b_done: done=%b err=%b ld=%h want 1 0 %h", o_done, o_err, o_ld_data, rd);
      end
      @(negedge i_clk);
   endtask

   task automatic test_reset_mid();
      @(negedge i_clk);
      i_mem_req = 1'b1; i_wren = 1'b0; i_load_type = 3'b010; i_addr = 32'h500;
      @(negedge i_clk);
      #1;
      n_cmp++;
      if (o_bus_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_pre: req=%b want 1", o_bus_req);
      end
      #1;
      i_reset = 1'b0; i_mem_req = 1'b0;
      #1;
      n_cmp++;
      if ({o_bus_req, o_stall, o_done, o_err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rst_mid_async: {req,stall,done,err}=%b want 0000", {o_bus_req, o_stall, o_done, o_err});
      end
      repeat (2) @(negedge i_clk);
      n_cmp++;
      if ({o_bus_req, o_done, o_err} !== 3'b000) begin
         n_bad++;
         $display("FAIL rst_mid_hold: {req,done,err}=%b want 000", {o_bus_req, o_done, o_err});
      end
      i_reset = 1'b1;
      do_access("post_reset", 1'b0, 3'b101, 3'd0, 32'h506, 32'h0, 1, 32'h9ABC_1234, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic        wr;
         logic [2:0]  lt, ss;
         logic [31:0] a, wd, rd;
         int          ack_at;
         wr = 1'($urandom);
         lt = 3'($urandom);
         ss = 3'($urandom);
         a  = $urandom;
         wd = $urandom;
         rd = $urandom;
         case ($urandom_range(0, 9))
            0:       ack_at = -1;
            1:       ack_at = TO - 1;
            default: ack_at = int'($urandom_range(0, 5));
         endcase
         do_access($sformatf("rnd%0d", i), wr, lt, ss, a, wd, ack_at, rd, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_misalign();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
